riscv_core_mdu: RTL and testbench
=================================

Name: riscv_core_mdu

Overview:
- RV64M multiply/divide unit in the EX stage. It produces the mbusy, mdone, mdivby0 and mof signals that the hazard unit consumes for pipeline stalls and exceptions.
- Multiply uses an iterative shift-add datapath; divide uses an iterative restoring datapath. Sign handling is magnitude-based with a sign fixup at the end.
- It holds the pipeline via busy/done until the result is ready, and supports abort on flush.

Parameters:
- XLEN, 64, operand/result width. Only 64 is supported; W-ops use the low 32 bits.

Ports:
- i_mdu_clk  in  1  clock
- i_mdu_rstn  in  1  synchronous active-low reset
- i_mdu_start  in  1  valid M-instruction present in EX; held high while stalled
- i_mdu_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_mdu_word  in  1  1 = *W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- i_mdu_a  in  XLEN  rs1 operand (post-forwarding)
- i_mdu_b  in  XLEN  rs2 operand (post-forwarding)
- i_mdu_flush  in  1  flush_ex; aborts the operation in flight
- o_mdu_result  out  XLEN  result, valid when o_mdu_done=1
- o_mdu_busy  out  1  unit occupied (mbusy)
- o_mdu_done  out  1  one-cycle completion pulse (mdone)
- o_mdu_divby0  out  1  divide-by-zero flag, pulses with done
- o_mdu_of  out  1  signed overflow (MIN/-1) flag, pulses with done

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: state=IDLE; result, done, divby0, of = 0; iteration counter = 0.
- FSM states and transitions:
  - IDLE -> CALC when start=1 and flush=0.
  - IDLE -> DONE directly on start for the divide special cases below.
  - CALC -> DONE when the counter reaches N-1 (N=64, or 32 if word).
  - DONE -> IDLE unconditionally.
- start is sampled only in IDLE. It is ignored in CALC and DONE, so a start still held during DONE does not retrigger.
- busy = (IDLE & start) | CALC | DONE, combinational from start so the stall takes effect in the issue cycle. The hazard stall equation busy & !done releases in the DONE cycle.
- done = (state==DONE), registered. divby0 and of are valid only while done=1 and are 0 otherwise.
- Latency: start sampled at edge of cycle T. Iterative ops give done at T+N+1 (T+65 for 64-bit, T+33 for W). Special cases give done at T+1.
- Operand prep:
  - W ops take a[31:0] and b[31:0], sign- or zero-extended per op.
  - Signed operands are converted to magnitudes; the result sign is recorded: MUL* uses sa^sb; DIV uses sa^sb; REM uses sa.
- Multiply:
  - 2N-bit accumulator, one multiplier bit per cycle.
  - MUL returns low XLEN; MULH/MULHSU/MULHU return high XLEN of the sign-corrected 128-bit product.
  - MULW returns sext(product[31:0]).
- Divide:
  - Restoring, one quotient bit per cycle; remainder register is N+1 bits.
  - Final negation is applied to quotient/remainder per the recorded sign.
  - W results are sign-extended from bit 31.
- Special cases (no iteration, done at T+1):
  - b==0 (low 32 for W): quotient = all ones; remainder = a (sext low 32 for W); divby0=1.
  - Signed DIV/REM with a = most-negative (0x8000_0000_0000_0000, or 0x8000_0000 for W) and b = -1: quotient = a, remainder = 0, of=1.
  - divby0 takes precedence over of; unsigned ops never set of.
- Result register holds its last value until the next DONE.
- flush=1 in any state forces IDLE next cycle, no done pulse. flush in DONE still allows the already-asserted done that cycle.
- Reset mid-operation returns to IDLE with all outputs 0 next cycle.
- Operands are latched at start; later changes on a/b/op are ignored.

Optional Feature:
- MDU_FAST_MUL_EN
  - Defined: multiplies use a combinational 128-bit product registered into DONE (IDLE -> DONE, done at T+1). Divide is unchanged.
  - Undefined: iterative multiply as above, done at T+65 (T+33 for MULW).

Test Plan:
- MUL a=7, b=-3 -> done at T+65 (T+1 with MDU_FAST_MUL_EN), result=0xFFFF_FFFF_FFFF_FFEB, busy high T..T+65, divby0=of=0.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> result=0.
- DIV a=-20, b=3 -> result=-6 (0xFFFF_FFFF_FFFF_FFFA); REM same operands -> result=-2; done at T+65.
- DIVU a=5, b=0 -> done at T+1, result=0xFFFF_FFFF_FFFF_FFFF, divby0=1. REMW a=0x1_8000_0000, b=-1 -> result=0, of=1 at T+1.
- DIVW a=0x0000_0000_FFFF_FFF8 (-8), b=2 -> result=0xFFFF_FFFF_FFFF_FFFC at T+33. start held high through DONE -> no second done.
- Mid-CALC flush at T+10 -> IDLE at T+11, busy=0, no done. Mid-CALC rstn=0 -> all outputs 0 next cycle; a new start then completes normally.

Source files
------------

// File: rtl/riscv_core_mdu.sv
// RV64M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a one-cycle product.
module riscv_core_mdu #(
    parameter int XLEN = 64
) (
    input  logic            i_mdu_clk,
    input  logic            i_mdu_rstn,
    input  logic            i_mdu_start,
    input  logic [2:0]      i_mdu_op,
    input  logic            i_mdu_word,
    input  logic [XLEN-1:0] i_mdu_a,
    input  logic [XLEN-1:0] i_mdu_b,
    input  logic            i_mdu_flush,
    output logic [XLEN-1:0] o_mdu_result,
    output logic            o_mdu_busy,
    output logic            o_mdu_done,
    output logic            o_mdu_divby0,
    output logic            o_mdu_of
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   shift_q, shift_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;
    logic              divby0_q, divby0_d;
    logic              of_q, of_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_fin(input logic [2*XLEN-1:0] p, input logic [1:0] sel,
                                                 input logic w, input logic n);
        logic [2*XLEN-1:0] sp;
        sp = n ? -p : p;
        if (w)
            return sext_w(sp[XLEN-1:0], 1'b1);
        return (sel == 2'b00) ? sp[XLEN-1:0] : sp[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_fin(input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem,
                                                 input logic rem_sel, input logic w, input logic n);
        logic [XLEN-1:0] r;
        r = rem_sel ? rem : quo;
        r = n ? -r : r;
        return sext_w(r, w);
    endfunction

    // Operand preparation: extension, magnitudes, result sign and divide special cases
    logic            is_div, is_rem, a_signed, b_signed;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, a_wext, spec_res;
    logic            neg_a, neg_b, res_neg, b_zero, a_min, b_m1, ovf;

    assign is_div   = i_mdu_op[2];
    assign is_rem   = i_mdu_op[2] & i_mdu_op[1];
    assign a_signed = (i_mdu_op != 3'd3) && !(is_div && i_mdu_op[0]);
    assign b_signed = (i_mdu_op[2:1] == 2'b00) || (is_div && !i_mdu_op[0]);

    always_comb begin
        if (i_mdu_word) begin
            ext_a = {{(XLEN-32){a_signed & i_mdu_a[31]}}, i_mdu_a[31:0]};
            ext_b = {{(XLEN-32){b_signed & i_mdu_b[31]}}, i_mdu_b[31:0]};
        end else begin
            ext_a = i_mdu_a;
            ext_b = i_mdu_b;
        end
    end

    assign neg_a    = a_signed & ext_a[XLEN-1];
    assign neg_b    = b_signed & ext_b[XLEN-1];
    assign mag_a    = neg_a ? -ext_a : ext_a;
    assign mag_b    = neg_b ? -ext_b : ext_b;
    assign res_neg  = is_rem ? neg_a : (neg_a ^ neg_b);
    assign b_zero   = (ext_b == '0);
    assign a_min    = i_mdu_word ? (i_mdu_a[31:0] == 32'h8000_0000)
                                 : (i_mdu_a == {1'b1, {(XLEN-1){1'b0}}});
    assign b_m1     = i_mdu_word ? (&i_mdu_b[31:0]) : (&i_mdu_b);
    assign ovf      = is_div & b_signed & a_min & b_m1;
    assign a_wext   = sext_w(i_mdu_a, i_mdu_word);
    assign spec_res = b_zero ? (is_rem ? a_wext : '1) : (is_rem ? '0 : a_wext);

    // One iteration step; the divisor sits in the low half of mcand_q during a divide
    logic [XLEN:0]     rem_shift;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_sum;
    logic              last_iter;

    assign rem_shift = {rem_q[XLEN-1:0], shift_q[XLEN-1]};
    assign div_ge    = (rem_shift >= {1'b0, mcand_q[XLEN-1:0]});
    assign mul_sum   = acc_q + (shift_q[0] ? mcand_q : '0);
    assign last_iter = (cnt_q == (word_q ? 6'd31 : 6'd63));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        divby0_d = 1'b0;
        of_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_mdu_start && !i_mdu_flush) begin
                    op_d    = i_mdu_op;
                    word_d  = i_mdu_word;
                    neg_d   = res_neg;
                    cnt_d   = '0;
                    acc_d   = '0;
                    rem_d   = '0;
                    mcand_d = {{XLEN{1'b0}}, (is_div ? mag_b : mag_a)};
                    // W divides pre-align the dividend so its MSB is always at the top
                    shift_d = !is_div ? mag_b :
                              (i_mdu_word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a);
                    if (is_div && (b_zero || ovf)) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        divby0_d = b_zero;
                        of_d     = ovf & !b_zero;
                        result_d = spec_res;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!is_div) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = mul_fin({{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b},
                                           i_mdu_op[1:0], i_mdu_word, res_neg);
                    end
`endif
                    else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (op_q[2]) begin
                    rem_d   = div_ge ? (rem_shift - {1'b0, mcand_q[XLEN-1:0]}) : rem_shift;
                    shift_d = {shift_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d   = mul_sum;
                    mcand_d = mcand_q << 1;
                    shift_d = shift_q >> 1;
                end
                cnt_d = cnt_q + 6'd1;
                if (i_mdu_flush) begin
                    state_d = ST_IDLE;
                end else if (last_iter) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = op_q[2] ? div_fin(shift_d, rem_d[XLEN-1:0], op_q[1], word_q, neg_q)
                                       : mul_fin(acc_d, op_q[1:0], word_q, neg_q);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_mdu_clk) begin
        if (!i_mdu_rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            divby0_q <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            divby0_q <= divby0_d;
            of_q     <= of_d;
        end
    end

    // Datapath registers are always loaded before use, so they carry no reset
    always_ff @(posedge i_mdu_clk) begin
        op_q    <= op_d;
        word_q  <= word_d;
        neg_q   <= neg_d;
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
        shift_q <= shift_d;
        rem_q   <= rem_d;
    end

    assign o_mdu_busy   = ((state_q == ST_IDLE) && i_mdu_start) || (state_q == ST_CALC) ||
                          (state_q == ST_DONE);
    assign o_mdu_result = result_q;
    assign o_mdu_done   = done_q;
    assign o_mdu_divby0 = divby0_q;
    assign o_mdu_of     = of_q;

endmodule

// File: tb/tb_riscv_core_mdu.sv
// Directed vector bench for riscv_core_mdu: latency, results, flags, flush and reset.
module tb_riscv_core_mdu;

    logic        clk = 1'b0;
    logic        rstn, start, word, flush;
    logic [2:0]  op;
    logic [63:0] a, b, result;
    logic        busy, done, divby0, of;

    always #5 clk = ~clk;

    riscv_core_mdu dut (
        .i_mdu_clk    (clk),
        .i_mdu_rstn   (rstn),
        .i_mdu_start  (start),
        .i_mdu_op     (op),
        .i_mdu_word   (word),
        .i_mdu_a      (a),
        .i_mdu_b      (b),
        .i_mdu_flush  (flush),
        .o_mdu_result (result),
        .o_mdu_busy   (busy),
        .o_mdu_done   (done),
        .o_mdu_divby0 (divby0),
        .o_mdu_of     (of)
    );

`ifdef MDU_FAST_MUL_EN
    localparam int ML64 = 1;
    localparam int ML32 = 1;
`else
    localparam int ML64 = 65;
    localparam int ML32 = 33;
`endif
    localparam int L64 = 65;
    localparam int L32 = 33;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
        logic        dz;
        logic        of;
        logic        hold;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s vec %0d: got %h want %h", name, idx, got, want);
    endtask

    task automatic add(input logic [2:0] o, input logic w, input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] r, input int l, input logic z, input logic f, input logic h);
        vec_t v;
        v.op = o; v.word = w; v.a = va; v.b = vb; v.res = r; v.lat = l; v.dz = z; v.of = f; v.hold = h;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   c;
        logic busy_ok;
        logic extra_done;
        op = v.op; word = v.word; a = v.a; b = v.b; start = 1'b1;
        #1;
        check("busy_issue", idx, 64'(busy), 64'd1);
        @(posedge clk); #1;
        c = 1;
        busy_ok = 1'b1;
        if (!v.hold) start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = ~v.op;
        while (!done && c < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        check("done", idx, 64'(done), 64'd1);
        check("latency", idx, 64'(c), 64'(v.lat));
        check("result", idx, result, v.res);
        check("divby0", idx, 64'(divby0), 64'(v.dz));
        check("of", idx, 64'(of), 64'(v.of));
        check("busy_hold", idx, 64'({busy_ok, busy}), 64'd3);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("done_clear", idx, 64'({done, divby0, of}), 64'd0);
        check("busy_clear", idx, 64'(busy), 64'd0);
        if (v.hold) begin
            extra_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                extra_done = extra_done | done | busy;
            end
            check("no_retrigger", idx, 64'(extra_done), 64'd0);
        end
    endtask

    initial begin
        logic        seen;
        logic [63:0] last_res;
        rstn = 1'b0; start = 1'b0; word = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;

        add(3'd0, 0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, ML64, 0, 0, 0);
        add(3'd3, 0, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, ML64, 0, 0, 0);
        add(3'd1, 0, ALL1, ALL1, 64'd0, ML64, 0, 0, 0);
        add(3'd2, 0, ALL1, 64'd2, ALL1, ML64, 0, 0, 0);
        add(3'd3, 0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, ML64, 0, 0, 0);
        add(3'd0, 1, 64'h1_0000_0003, 64'h0_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, ML32, 0, 0, 0);
        add(3'd0, 1, 64'h1_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, ML32, 0, 0, 0);
        add(3'd4, 0, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, L64, 0, 0, 0);
        add(3'd6, 0, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, L64, 0, 0, 0);
        add(3'd5, 0, 64'd100, 64'd7, 64'd14, L64, 0, 0, 0);
        add(3'd7, 0, 64'd100, 64'd7, 64'd2, L64, 0, 0, 0);
        add(3'd5, 0, 64'd5, 64'd0, ALL1, 1, 1, 0, 0);
        add(3'd6, 0, 64'd5, 64'd0, 64'd5, 1, 1, 0, 0);
        add(3'd4, 0, MIN, 64'd0, ALL1, 1, 1, 0, 0);
        add(3'd4, 0, MIN, ALL1, MIN, 1, 0, 1, 0);
        add(3'd6, 1, 64'h1_8000_0000, ALL1, 64'd0, 1, 0, 1, 0);
        add(3'd4, 1, 64'h0_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, L32, 0, 0, 1);
        add(3'd5, 1, 64'h0_FFFF_FFF8, 64'd2, 64'h0000_0000_7FFF_FFFC, L32, 0, 0, 0);
        add(3'd7, 1, 64'h1_0000_0007, 64'h5_0000_0000, 64'd7, 1, 1, 0, 0);
        add(3'd4, 1, 64'd5, ALL1, 64'hFFFF_FFFF_FFFF_FFFB, L32, 0, 0, 0);
        add(3'd5, 0, MIN, ALL1, 64'd0, L64, 0, 0, 0);
        add(3'd6, 0, MIN, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, L64, 0, 0, 0);
        add(3'd4, 0, 64'd7, -64'd2, 64'hFFFF_FFFF_FFFF_FFFD, L64, 0, 0, 0);
        add(3'd6, 0, 64'd7, -64'd2, 64'd1, L64, 0, 0, 0);
        add(3'd5, 0, ALL1, 64'd1, ALL1, L64, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", -1, 64'({done, divby0, of, busy}), 64'd0);
        check("reset_result", -1, result, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
            $display("vec %0d op=%0d w=%0d a=%h b=%h -> result=%h dz=%0d of=%0d", i, vecs[i].op,
                     vecs[i].word, vecs[i].a, vecs[i].b, result, divby0, of);
        end
        last_res = vecs[vecs.size()-1].res;

        // Flush during an iterative divide: unit idles and the old result stays
        op = 3'd4; word = 1'b0; a = 64'd100; b = 64'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 100, 64'({busy, done}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            seen = seen | done | busy;
        end
        check("flush_no_done", 100, 64'(seen), 64'd0);
        check("flush_result_kept", 100, result, last_res);
        $display("flush sequence: busy=%0d done=%0d result=%h", busy, done, result);

        // Reset during an iterative multiply clears everything, then a new op completes
        op = 3'd0; word = 1'b0; a = 64'd9; b = 64'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midreset_outputs", 101, 64'({busy, done, divby0, of}), 64'd0);
        check("midreset_result", 101, result, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        $display("reset sequence: busy=%0d done=%0d result=%h", busy, done, result);
        run_vec(102, vecs[9]);
        $display("post-reset op: result=%h", result);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
